// File: rtl/fft_frame_feeder.sv
// Streams one packed frame of samples into an FFT core, one extended word per
// handshake, then pulses fft_start and waits for the core to report completion.
module fft_frame_feeder #(
    parameter int N_SAMPLES = 512,
    parameter int SAMPLE_W  = 8,
    parameter int WORD_W    = 32,
    parameter int LSB_POS   = 16,
    parameter int SIGNED    = 0,
    localparam int FRAME_W  = N_SAMPLES * SAMPLE_W,
    localparam int IDX_W    = $clog2(N_SAMPLES)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [FRAME_W-1:0] i_frame_in,
    input  logic               i_frame_valid,
    output logic               o_frame_ready,
    input  logic               i_abort,
    output logic [WORD_W-1:0]  o_word_out,
    output logic               o_word_valid,
    input  logic               i_word_ready,
    output logic               o_fft_start,
    input  logic               i_core_done,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_overrun,
    input  logic               i_clear_overrun,
    output logic [15:0]        o_frame_count,
    output logic [1:0]         o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_START = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [FRAME_W-1:0]  r_shift;
    logic [IDX_W-1:0]    r_idx;
    logic                r_overrun;
    logic [15:0]         r_frame_count;
    logic                w_accept;
    logic                w_fire;
    logic                w_last;
    logic [SAMPLE_W-1:0] w_sample;
    logic [WORD_W-1:0]   w_word;

    // A word transfers on the edge where word_valid and word_ready are both
    // high; word_valid never depends on word_ready, and word_out/idx hold
    // steady while word_valid is high and word_ready is low.
    assign w_accept = (r_state == ST_IDLE) && i_frame_valid && !i_abort;
    assign w_fire   = (r_state == ST_SEND) && i_word_ready;
    assign w_last   = (r_idx == IDX_W'(N_SAMPLES - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_SEND;
            ST_SEND:  if (w_fire && w_last) w_next_state = ST_START;
            ST_START: w_next_state = ST_DRAIN;
            ST_DRAIN: if (i_core_done) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (i_abort) w_next_state = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= i_frame_in;
            end else if (w_fire) begin
                r_shift <= r_shift << SAMPLE_W;
            end
            if (i_abort || w_accept) begin
                r_idx <= '0;
            end else if (w_fire && !w_last) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // A frame offered outside IDLE is dropped; setting beats a same-cycle clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (i_frame_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (i_clear_overrun) begin
                r_overrun <= 1'b0;
            end
            if ((r_state == ST_START) && !i_abort) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_sample = r_shift[FRAME_W-1 -: SAMPLE_W];
        w_word   = '0;
        w_word[LSB_POS +: SAMPLE_W] = w_sample;
        if (SIGNED != 0) begin
            for (int b = LSB_POS + SAMPLE_W; b < WORD_W; b++) begin
                w_word[b] = w_sample[SAMPLE_W-1];
            end
        end
    end

    assign o_frame_ready = (r_state == ST_IDLE);
    assign o_word_valid  = (r_state == ST_SEND);
    assign o_fft_start   = (r_state == ST_START);
    assign o_word_out    = (r_state == ST_SEND) ? w_word : '0;
    assign o_idx         = r_idx;
    assign o_overrun     = r_overrun;
    assign o_frame_count = r_frame_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: zero- and sign-extending instances run in lockstep,
// words checked against a queue of expected values filled from a vector table.
module tb_fft_frame_feeder;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] frame_in;
    logic        frame_valid;
    logic        abort;
    logic        word_ready;
    logic        core_done;
    logic        clear_overrun;

    logic        o_frame_ready_u, o_word_valid_u, o_fft_start_u, o_overrun_u;
    logic [31:0] o_word_out_u;
    logic [1:0]  o_idx_u, o_state_u;
    logic [15:0] o_frame_count_u;
    logic        o_frame_ready_s, o_word_valid_s, o_fft_start_s, o_overrun_s;
    logic [31:0] o_word_out_s;
    logic [1:0]  o_idx_s, o_state_s;
    logic [15:0] o_frame_count_s;

    fft_frame_feeder #(.N_SAMPLES(N), .SAMPLE_W(8), .WORD_W(32), .LSB_POS(16), .SIGNED(0)) dut_u (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_in(frame_in), .i_frame_valid(frame_valid),
        .o_frame_ready(o_frame_ready_u), .i_abort(abort), .o_word_out(o_word_out_u),
        .o_word_valid(o_word_valid_u), .i_word_ready(word_ready), .o_fft_start(o_fft_start_u),
        .i_core_done(core_done), .o_idx(o_idx_u), .o_overrun(o_overrun_u),
        .i_clear_overrun(clear_overrun), .o_frame_count(o_frame_count_u), .o_state(o_state_u)
    );

    fft_frame_feeder #(.N_SAMPLES(N), .SAMPLE_W(8), .WORD_W(32), .LSB_POS(16), .SIGNED(1)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_in(frame_in), .i_frame_valid(frame_valid),
        .o_frame_ready(o_frame_ready_s), .i_abort(abort), .o_word_out(o_word_out_s),
        .o_word_valid(o_word_valid_s), .i_word_ready(word_ready), .o_fft_start(o_fft_start_s),
        .i_core_done(core_done), .o_idx(o_idx_s), .o_overrun(o_overrun_s),
        .i_clear_overrun(clear_overrun), .o_frame_count(o_frame_count_s), .o_state(o_state_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      frame;
        logic [3:0][31:0] exp_u;
        logic [3:0][31:0] exp_s;
        int               mode;   // 0: ready high, 1: 3-cycle stall at idx 2, 2: random
    } vec_t;

    vec_t        tab[4];
    logic [31:0] exp_u_q[$];
    logic [31:0] exp_s_q[$];
    logic [1:0]  exp_idx_q[$];
    logic [15:0] exp_count;
    logic        exp_ov;
    logic        mon_en;
    int          n_checks;
    int          n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [31:0] f,
                                input logic [31:0] u0, input logic [31:0] u1,
                                input logic [31:0] u2, input logic [31:0] u3,
                                input logic [31:0] s0, input logic [31:0] s1,
                                input logic [31:0] s2, input logic [31:0] s3, input int m);
        vec_t v;
        v.frame = f;
        v.exp_u[0] = u0; v.exp_u[1] = u1; v.exp_u[2] = u2; v.exp_u[3] = u3;
        v.exp_s[0] = s0; v.exp_s[1] = s1; v.exp_s[2] = s2; v.exp_s[3] = s3;
        v.mode = m;
        return v;
    endfunction

    function automatic logic [31:0] stat_u();
        return {8'd0, o_state_u, o_frame_ready_u, o_word_valid_u, o_fft_start_u, o_overrun_u, o_idx_u, o_frame_count_u};
    endfunction

    function automatic logic [31:0] stat_s();
        return {8'd0, o_state_s, o_frame_ready_s, o_word_valid_s, o_fft_start_s, o_overrun_s, o_idx_s, o_frame_count_s};
    endfunction

    function automatic logic [31:0] exp_stat(input logic [1:0] st, input logic fr, input logic wv,
                                             input logic fs, input logic ov, input logic [1:0] ix,
                                             input logic [15:0] cnt);
        return {8'd0, st, fr, wv, fs, ov, ix, cnt};
    endfunction

    // scoreboard: a word leaves the DUT on each valid && ready cycle
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (o_word_valid_u && word_ready) begin
                if (exp_u_q.size() == 0) begin
                    check("unexpected_word", o_word_out_u, 32'hFFFF_FFFF);
                end else begin
                    check("word_u", o_word_out_u, exp_u_q.pop_front());
                    check("word_s", o_word_out_s, exp_s_q.pop_front());
                    check("idx", {28'd0, o_idx_u, o_idx_s}, {28'd0, exp_idx_q[0], exp_idx_q[0]});
                    void'(exp_idx_q.pop_front());
                end
            end else if (!o_word_valid_u) begin
                check("word_idle_zero", o_word_out_u | o_word_out_s, 32'd0);
            end
        end
    end

    // driver: offer a frame, pace word_ready, measure start latency
    task automatic run_frame(input int e, input int inject_cyc);
        int cyc;
        int stalls;
        bit seen;
        frame_in    = tab[e].frame;
        frame_valid = 1'b1;
        for (int k = 0; k < N; k++) begin
            exp_u_q.push_back(tab[e].exp_u[k]);
            exp_s_q.push_back(tab[e].exp_s[k]);
            exp_idx_q.push_back(2'(k));
        end
        @(posedge clk); #1;
        frame_valid = 1'b0;
        cyc = 0; stalls = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            case (tab[e].mode)
                0:       word_ready = 1'b1;
                1:       word_ready = !(cyc >= 2 && cyc <= 4);
                default: word_ready = 1'($urandom_range(0, 1));
            endcase
            core_done = (cyc == 1);
            if (cyc == inject_cyc) begin
                frame_valid = 1'b1;
                frame_in    = 32'hDEAD_BEEF;
                exp_ov      = 1'b1;
            end else begin
                frame_valid = 1'b0;
            end
            @(negedge clk);
            if (o_fft_start_u) begin
                seen = 1'b1;
            end else begin
                if (o_word_valid_u && !word_ready) begin
                    stalls++;
                    check("hold_word", o_word_out_u, exp_u_q[0]);
                    check("hold_idx", 32'(o_idx_u), 32'(exp_idx_q[0]));
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        frame_valid = 1'b0;
        core_done   = 1'b0;
        word_ready  = 1'b1;
        check("start_seen", 32'(seen), 32'd1);
        check("start_latency", 32'(cyc), 32'(N + stalls));
        if (tab[e].mode == 1) check("stall_cycles", 32'(stalls), 32'd3);
        check("start_s", 32'(o_fft_start_s), 32'd1);
        exp_count++;
        @(posedge clk); #1;
        @(negedge clk);
        check("start_one_cycle", {30'd0, o_fft_start_u, o_fft_start_s}, 32'd0);
        check("frame_count_u", 32'(o_frame_count_u), 32'(exp_count));
        check("frame_count_s", 32'(o_frame_count_s), 32'(exp_count));
        check("overrun", {30'd0, o_overrun_u, o_overrun_s}, {30'd0, exp_ov, exp_ov});
        check("ready_low_drain", {30'd0, o_frame_ready_u, o_frame_ready_s}, 32'd0);
        check("exp_q_empty", 32'(exp_u_q.size()), 32'd0);
    endtask

    task automatic drain(input bit ovr_pulse);
        if (ovr_pulse) begin
            frame_valid   = 1'b1;
            clear_overrun = 1'b1;
            frame_in      = 32'h5555_AAAA;
            exp_ov        = 1'b1;
            @(posedge clk); #1;
            frame_valid   = 1'b0;
            clear_overrun = 1'b0;
            @(negedge clk);
            check("overrun_set_wins", {30'd0, o_overrun_u, o_overrun_s}, 32'd3);
            check("drain_holds", 32'(o_state_u), 32'd3);
        end
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        @(negedge clk);
        check("ready_after_done", {30'd0, o_frame_ready_u, o_frame_ready_s}, 32'd3);
    endtask

    initial begin
        bit saw;
        n_checks = 0; n_pass = 0;
        rst_n = 1'b0; frame_in = '0; frame_valid = 1'b0; abort = 1'b0;
        word_ready = 1'b1; core_done = 1'b0; clear_overrun = 1'b0;
        exp_count = '0; exp_ov = 1'b0; mon_en = 1'b0;

        tab[0] = mk(32'h7F80_0102, 32'h007F_0000, 32'h0080_0000, 32'h0001_0000, 32'h0002_0000,
                    32'h007F_0000, 32'hFF80_0000, 32'h0001_0000, 32'h0002_0000, 0);
        tab[1] = mk(32'hFF00_AA55, 32'h00FF_0000, 32'h0000_0000, 32'h00AA_0000, 32'h0055_0000,
                    32'hFFFF_0000, 32'h0000_0000, 32'hFFAA_0000, 32'h0055_0000, 1);
        tab[2] = mk(32'h0180_7FFE, 32'h0001_0000, 32'h0080_0000, 32'h007F_0000, 32'h00FE_0000,
                    32'h0001_0000, 32'hFF80_0000, 32'h007F_0000, 32'hFFFE_0000, 2);
        tab[3] = mk(32'h1234_C3E0, 32'h0012_0000, 32'h0034_0000, 32'h00C3_0000, 32'h00E0_0000,
                    32'h0012_0000, 32'h0034_0000, 32'hFFC3_0000, 32'hFFE0_0000, 2);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_u", stat_u(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
        check("reset_s", stat_s(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
        check("reset_word", o_word_out_u | o_word_out_s, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // table-driven frames: basic stream, then back-pressure
        run_frame(0, -1); drain(1'b0);
        run_frame(1, -1); drain(1'b0);

        // overrun during SEND, then again in DRAIN together with a clear
        run_frame(0, 1); drain(1'b1);
        clear_overrun = 1'b1;
        @(posedge clk); #1;
        clear_overrun = 1'b0;
        exp_ov = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {30'd0, o_overrun_u, o_overrun_s}, 32'd0);

        // abort and frame_valid in the same IDLE cycle
        frame_in = tab[2].frame; frame_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("abort_beats_frame", stat_u(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, exp_ov, 2'd0, exp_count));

        // abort at idx 1
        frame_in = tab[3].frame; frame_valid = 1'b1; word_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            exp_u_q.push_back(tab[3].exp_u[k]);
            exp_s_q.push_back(tab[3].exp_s[k]);
            exp_idx_q.push_back(2'(k));
        end
        @(posedge clk); #1;
        frame_valid = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_at_idx", 32'(o_idx_u), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0;
        exp_u_q.delete(); exp_s_q.delete(); exp_idx_q.delete();
        @(negedge clk);
        check("abort_u", stat_u(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, exp_ov, 2'd0, exp_count));
        check("abort_s", stat_s(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, exp_ov, 2'd0, exp_count));
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw = saw | o_fft_start_u | o_fft_start_s;
        end
        check("abort_no_start", 32'(saw), 32'd0);

        // random back-pressure frames after the abort
        run_frame(2, -1); drain(1'b0);
        run_frame(3, -1); drain(1'b0);

        // asynchronous reset in the middle of SEND
        mon_en = 1'b0;
        frame_in = tab[3].frame; frame_valid = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(posedge clk); #1;
        frame_valid = 1'b0;
        check("pre_reset_busy", {30'd0, o_overrun_u, o_word_valid_u}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_u", stat_u(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
        check("async_reset_s", stat_s(), exp_stat(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
        check("async_reset_word", o_word_out_u | o_word_out_s, 32'd0);
        #1 rst_n = 1'b1;
        exp_count = '0; exp_ov = 1'b0;
        exp_u_q.delete(); exp_s_q.delete(); exp_idx_q.delete();
        @(negedge clk);
        mon_en = 1'b1;

        // frame counter wrap from a preloaded 65535
        @(posedge clk); #1;
        force dut_u.r_frame_count = 16'hFFFF;
        force dut_s.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut_u.r_frame_count;
        release dut_s.r_frame_count;
        #1;
        check("preload", {o_frame_count_u, o_frame_count_s}, 32'hFFFF_FFFF);
        exp_count = 16'hFFFF;
        run_frame(0, -1); drain(1'b0);
        check("wrap_zero", {o_frame_count_u, o_frame_count_s}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
